// File: rtl/axi4_pkg.sv
// Package for the LSU AXI4 initiator.
// Holds the AXI burst, response and size encodings, the FSM state type and
// a helper that flags requests whose address does not match their size.
package axi4_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] SIZE_B = 3'd0;
  localparam logic [2:0] SIZE_H = 3'd1;
  localparam logic [2:0] SIZE_W = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4
  } lsu_state_t;

  // Sizes above a word are not supported and count as misaligned.
  function automatic logic misaligned(input logic [1:0] addr_lo, input logic [2:0] size);
    return (size > SIZE_W) ||
           ((size == SIZE_H) && addr_lo[0]) ||
           ((size == SIZE_W) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/axi4_lsu_master.sv
// axi4_lsu_master: single-outstanding AXI4 initiator for LSU load/store traffic.
// One single-beat request in, one AXI4 transaction out, one rsp_valid pulse back.
//
// Optional build macro: AXI_MASTER_ALIGN_CHECK_EN
//   defined   - misaligned / oversized requests are answered locally with
//               rsp_err=1 the cycle after acceptance, no AXI traffic.
//   undefined - every request is forwarded; the target decides.
//
// Ports:
//   clock, reset              single clock, synchronous active-high reset
//   req_*                     LSU request (valid/ready, wen, addr, size, wdata, wstrb)
//   rsp_valid/rdata/err       one-cycle response pulse
//   M_AXI_AR*/R*              read address / read data channels
//   M_AXI_AW*/W*/B*           write address / write data / write response channels
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | req_ready=1, waiting for a request
// ST_RD_ADDR | ARVALID held until ARREADY
// ST_RD_DATA | RREADY held until the single R beat
// ST_WR_REQ  | AWVALID and WVALID raised together, each drops on its handshake
// ST_WR_RESP | BREADY held until BVALID
module axi4_lsu_master
  import axi4_pkg::*;
#(
  parameter int              ADDR_W = 32,
  parameter int              DATA_W = 32,
  parameter int              ID_W   = 4,
  parameter logic [ID_W-1:0] AXI_ID = 4'h1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [2:0]          req_size,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [ADDR_W-1:0]   M_AXI_ARADDR,
  output logic                M_AXI_ARVALID,
  input  logic                M_AXI_ARREADY,
  output logic [ID_W-1:0]     M_AXI_ARID,
  output logic [7:0]          M_AXI_ARLEN,
  output logic [2:0]          M_AXI_ARSIZE,
  output logic [1:0]          M_AXI_ARBURST,
  input  logic [DATA_W-1:0]   M_AXI_RDATA,
  input  logic [1:0]          M_AXI_RRESP,
  input  logic                M_AXI_RVALID,
  output logic                M_AXI_RREADY,
  input  logic                M_AXI_RLAST,
  input  logic [ID_W-1:0]     M_AXI_RID,
  output logic [ADDR_W-1:0]   M_AXI_AWADDR,
  output logic                M_AXI_AWVALID,
  input  logic                M_AXI_AWREADY,
  output logic [ID_W-1:0]     M_AXI_AWID,
  output logic [7:0]          M_AXI_AWLEN,
  output logic [2:0]          M_AXI_AWSIZE,
  output logic [1:0]          M_AXI_AWBURST,
  output logic [DATA_W-1:0]   M_AXI_WDATA,
  output logic [DATA_W/8-1:0] M_AXI_WSTRB,
  output logic                M_AXI_WVALID,
  output logic                M_AXI_WLAST,
  input  logic                M_AXI_WREADY,
  input  logic [1:0]          M_AXI_BRESP,
  input  logic                M_AXI_BVALID,
  output logic                M_AXI_BREADY,
  input  logic [ID_W-1:0]     M_AXI_BID
);

  lsu_state_t          r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [2:0]          r_size;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wstrb;
  logic                r_arvalid, r_rready, r_awvalid, r_wvalid, r_bready;
  logic                r_aw_done, r_w_done;
  logic                r_rsp_valid, r_rsp_err;
  logic [DATA_W-1:0]   r_rsp_rdata;

  logic w_accept, w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs;
  logic w_aw_fin, w_w_fin, w_bad_align;

  assign req_ready = (r_state == ST_IDLE) && !reset;
  assign w_accept  = req_valid && req_ready;
  assign w_ar_hs   = r_arvalid && M_AXI_ARREADY;
  assign w_r_hs    = r_rready  && M_AXI_RVALID;
  assign w_aw_hs   = r_awvalid && M_AXI_AWREADY;
  assign w_w_hs    = r_wvalid  && M_AXI_WREADY;
  assign w_b_hs    = r_bready  && M_AXI_BVALID;
  // A channel is finished if it completed earlier or completes this cycle.
  assign w_aw_fin  = r_aw_done || w_aw_hs;
  assign w_w_fin   = r_w_done  || w_w_hs;

`ifdef AXI_MASTER_ALIGN_CHECK_EN
  assign w_bad_align = misaligned(req_addr[1:0], req_size);
`else
  assign w_bad_align = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_size      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr  <= req_addr;
            r_size  <= req_size;
            r_wdata <= req_wdata;
            r_wstrb <= req_wstrb;
            if (w_bad_align) begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
            end else if (req_wen) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
              r_state   <= ST_WR_REQ;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= ST_RD_ADDR;
            end
          end
        end
        ST_RD_ADDR: begin
          if (w_ar_hs) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (w_r_hs) begin
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= M_AXI_RDATA;
            // Single-beat burst: a missing RLAST or foreign ID is a protocol error.
            r_rsp_err   <= M_AXI_RRESP[1] || !M_AXI_RLAST || (M_AXI_RID != AXI_ID);
            r_state     <= ST_IDLE;
          end
        end
        ST_WR_REQ: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_aw_fin && w_w_fin) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_bready  <= 1'b1;
            r_state   <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (w_b_hs) begin
            r_bready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= '0;
            r_rsp_err   <= M_AXI_BRESP[1] || (M_AXI_BID != AXI_ID);
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_err       = r_rsp_err;

  assign M_AXI_ARADDR  = r_addr;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_ARID    = AXI_ID;
  assign M_AXI_ARLEN   = 8'd0;
  assign M_AXI_ARSIZE  = r_size;
  assign M_AXI_ARBURST = AXI_BURST_INCR;
  assign M_AXI_RREADY  = r_rready;

  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_AWID    = AXI_ID;
  assign M_AXI_AWLEN   = 8'd0;
  assign M_AXI_AWSIZE  = r_size;
  assign M_AXI_AWBURST = AXI_BURST_INCR;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = r_wstrb;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_WLAST   = 1'b1;
  assign M_AXI_BREADY  = r_bready;

endmodule

// File: tb/tb_axi4_lsu_master.sv
// Bench for axi4_lsu_master: directed cases followed by randomized
// transactions against a cycle-level AXI slave with chosen wait states.
// Expected response, latency and channel traffic come from the
// transaction-level rules (handshake counts, delay arithmetic).
module tb_axi4_lsu_master;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_size;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [3:0]  arid, awid, rid, bid, wstrb;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  axi4_lsu_master dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_ARID(arid), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize), .M_AXI_ARBURST(arburst),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
    .M_AXI_RLAST(rlast), .M_AXI_RID(rid),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_AWID(awid), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize), .M_AXI_AWBURST(awburst),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WLAST(wlast),
    .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_BID(bid)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic slave_idle();
    arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0; rid = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
  endtask

  // One request end to end. Called at a sample point (posedge+1) with the DUT idle.
  task automatic run_txn(input logic wen, input logic [31:0] addr, input logic [2:0] size,
                         input logic [31:0] wd, input logic [3:0] ws,
                         input int ar_dly, input int r_dly, input int aw_dly,
                         input int w_dly, input int b_dly,
                         input logic [1:0] resp, input logic last, input logic [3:0] id,
                         input logic [31:0] rd);
    int  exp_lat, n_ar, n_r, n_aw, n_w, n_b;
    int  ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    bit  r_pend, b_pend, b_started, aw_seen, w_seen, got_rsp, bad_align, align_en;
    bit  p_arv, p_awv, p_wv;
    logic [31:0] p_araddr, p_awaddr, p_wdata, exp_rdata;
    logic exp_err;
    n_ar = 0; n_r = 0; n_aw = 0; n_w = 0; n_b = 0;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    r_pend = 0; b_pend = 0; b_started = 0; aw_seen = 0; w_seen = 0; got_rsp = 0;
    p_arv = 0; p_awv = 0; p_wv = 0; p_araddr = 0; p_awaddr = 0; p_wdata = 0;
    bad_align = (size > 3'd2) || (size == 3'd1 && addr[0]) || (size == 3'd2 && addr[1:0] != 2'b00);
`ifdef AXI_MASTER_ALIGN_CHECK_EN
    align_en = 1;
`else
    align_en = 0;
`endif
    if (align_en && bad_align) begin
      exp_lat = 1; exp_err = 1; exp_rdata = 0;
    end else if (wen) begin
      exp_lat = 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly;
      exp_err = resp[1] || (id != 4'h1);
      exp_rdata = 0;
    end else begin
      exp_lat = 3 + ar_dly + r_dly;
      exp_err = resp[1] || !last || (id != 4'h1);
      exp_rdata = rd;
    end

    check("req_ready_idle", req_ready, 1);
    req_valid = 1; req_wen = wen; req_addr = addr; req_size = size;
    req_wdata = wd; req_wstrb = ws;

    for (int cyc = 1; cyc <= 80 && !got_rsp; cyc++) begin
      tick();
      if (cyc == 1) begin
        // Scramble request lines so the DUT must be using its latched copy.
        req_valid = 0; req_addr = $urandom; req_wdata = $urandom;
        req_size = 3'($urandom_range(0, 2)); req_wstrb = 4'($urandom);
        req_wen = 1'($urandom);
      end
      if (p_arv) begin
        check("arvalid_hold", arvalid, 1);
        check("araddr_hold", araddr, p_araddr);
      end
      if (p_awv) begin
        check("awvalid_hold", awvalid, 1);
        check("awaddr_hold", awaddr, p_awaddr);
      end
      if (p_wv) begin
        check("wvalid_hold", wvalid, 1);
        check("wdata_hold", wdata, p_wdata);
      end

      rvalid = r_pend && (r_cnt >= r_dly);
      if (r_pend) r_cnt++;
      rdata = rvalid ? rd : $urandom;
      rresp = resp; rlast = last; rid = id;
      if (rvalid && rready) begin n_r++; r_pend = 0; end

      arready = arvalid && (ar_cnt >= ar_dly);
      if (arvalid) ar_cnt++;
      if (arvalid && arready) begin
        n_ar++; r_pend = 1;
        check("araddr", araddr, addr);
        check("arsize", arsize, size);
        check("arid", arid, 4'h1);
        check("arlen", arlen, 0);
        check("arburst", arburst, 2'b01);
      end
      p_arv = arvalid && !arready; p_araddr = araddr;

      bvalid = b_pend && (b_cnt >= b_dly);
      if (b_pend) b_cnt++;
      bresp = resp; bid = id;
      if (bvalid && bready) begin n_b++; b_pend = 0; end

      awready = awvalid && (aw_cnt >= aw_dly);
      if (awvalid) aw_cnt++;
      if (awvalid && awready) begin
        n_aw++; aw_seen = 1;
        check("awaddr", awaddr, addr);
        check("awsize", awsize, size);
        check("awid", awid, 4'h1);
        check("awlen", awlen, 0);
        check("awburst", awburst, 2'b01);
      end
      p_awv = awvalid && !awready; p_awaddr = awaddr;

      wready = wvalid && (w_cnt >= w_dly);
      if (wvalid) w_cnt++;
      if (wvalid && wready) begin
        n_w++; w_seen = 1;
        check("wdata", wdata, wd);
        check("wstrb", wstrb, ws);
        check("wlast", wlast, 1);
      end
      p_wv = wvalid && !wready; p_wdata = wdata;

      if (aw_seen && w_seen && !b_started) begin b_pend = 1; b_started = 1; end

      if (rsp_valid) begin
        got_rsp = 1;
        check("rsp_latency", 64'(cyc), 64'(exp_lat));
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("rsp_err", rsp_err, exp_err);
        check("req_ready_at_rsp", req_ready, 1);
      end
    end
    if (!got_rsp) check("rsp_timeout", 0, 1);
    check("ar_count", 64'(n_ar), (!wen && !(align_en && bad_align)) ? 1 : 0);
    check("r_count",  64'(n_r),  (!wen && !(align_en && bad_align)) ? 1 : 0);
    check("aw_count", 64'(n_aw), (wen && !(align_en && bad_align)) ? 1 : 0);
    check("w_count",  64'(n_w),  (wen && !(align_en && bad_align)) ? 1 : 0);
    check("b_count",  64'(n_b),  (wen && !(align_en && bad_align)) ? 1 : 0);
  endtask

  initial begin
    logic        wen, last;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [1:0]  resp;
    logic [3:0]  id;
    req_valid = 0; req_wen = 0; req_addr = 0; req_size = 0; req_wdata = 0; req_wstrb = 0;
    slave_idle();
    reset = 1;
    repeat (3) tick();
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_valids", {arvalid, awvalid, wvalid, rready, bready}, 0);
    reset = 0;
    tick();

    // Zero-wait read.
    run_txn(0, 32'h0200_0000, 3'd2, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 4'h1, 32'h1234_5678);
    // Write, WREADY two cycles ahead of AWREADY.
    run_txn(1, 32'h0200_0004, 3'd2, 32'hDEAD_BEEF, 4'hF, 0, 0, 2, 0, 0, 2'b00, 1, 4'h1, 0);
    // Slow read with SLVERR and delayed address handshake.
    run_txn(0, 32'h0200_0008, 3'd2, 0, 0, 3, 5, 0, 0, 0, 2'b10, 1, 4'h1, 32'hCAFE_0001);
    // EXOKAY is success, DECERR is an error.
    run_txn(1, 32'h0200_000C, 3'd2, 32'h0BAD_F00D, 4'h3, 0, 0, 0, 0, 1, 2'b01, 1, 4'h1, 0);
    run_txn(1, 32'h0200_0010, 3'd1, 32'h5555_0000, 4'hC, 0, 0, 1, 3, 0, 2'b11, 1, 4'h1, 0);
    // Missing RLAST and foreign IDs.
    run_txn(0, 32'h1000_0000, 3'd0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 4'h1, 32'hAAAA_5555);
    run_txn(0, 32'h1000_0004, 3'd2, 0, 0, 0, 1, 0, 0, 0, 2'b00, 1, 4'h3, 32'h0000_00FF);
    run_txn(1, 32'h1000_0008, 3'd2, 32'h1111_2222, 4'hF, 0, 0, 0, 0, 0, 2'b00, 1, 4'h2, 0);
    // Misaligned word read: rejected locally only when the alignment check is built in.
    run_txn(0, 32'h8000_0002, 3'd2, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 4'h1, 32'h7777_8888);

    // Reset while waiting for R data.
    tick();
    req_valid = 1; req_wen = 0; req_addr = 32'h0300_0000; req_size = 3'd2;
    tick();
    req_valid = 0;
    arready = arvalid;
    tick();
    arready = 0;
    check("mid_rready", rready, 1);
    reset = 1;
    tick();
    check("mid_rst_arvalid", arvalid, 0);
    check("mid_rst_rready", rready, 0);
    check("mid_rst_rsp", rsp_valid, 0);
    check("mid_rst_req_ready", req_ready, 0);
    reset = 0;
    tick();
    check("post_rst_req_ready", req_ready, 1);
    for (int i = 0; i < 4; i++) begin
      rvalid = 1; rdata = 32'hFFFF_FFFF; rlast = 1; rid = 4'h1;
      tick();
      check("post_rst_no_rsp", rsp_valid, 0);
      check("post_rst_rready", rready, 0);
    end
    slave_idle();

    // Randomized traffic.
    for (int t = 0; t < 200; t++) begin
      wen  = 1'($urandom);
      size = 3'($urandom_range(0, 2));
      addr = $urandom;
      if ($urandom_range(0, 7) != 0) begin
        if (size == 3'd1) addr[0] = 1'b0;
        if (size == 3'd2) addr[1:0] = 2'b00;
      end
      resp = 2'($urandom);
      last = ($urandom_range(0, 7) != 0);
      id   = ($urandom_range(0, 7) != 0) ? 4'h1 : 4'($urandom);
      run_txn(wen, addr, size, $urandom, 4'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3),
              resp, last, id, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
